// File: rtl/seq_dot_mac_pkg.sv
// Package for the digit-serial dot-product MAC.
// Holds the FSM state type and two helpers:
//   digit_ext - extends one operand digit to the signed lane width
//   clamp_sat - clamps a wide signed accumulator into a narrower signed range
// Optional feature macro used by the top: SEQ_DOT_MAC_SATURATE_EN.
package seq_dot_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Upper bound on the digit width the helpers can handle.
    localparam int DIG_MAX = 8;

    // Extend the low pw bits of value to pw+1 bits. Only the most significant
    // digit (idx == n-1) of a signed operand carries a sign; every other digit
    // is a plain unsigned magnitude and is zero-extended.
    function automatic logic [DIG_MAX:0] digit_ext(
        input logic [DIG_MAX-1:0] value,
        input logic [7:0]         idx,
        input logic [7:0]         n,
        input logic               sgn,
        input int unsigned        pw
    );
        logic             fill;
        logic [DIG_MAX:0] ext;
        fill = sgn & (idx == (n - 8'd1)) & value[pw-1];
        for (int b = 0; b <= DIG_MAX; b++) begin
            ext[b] = (b < int'(pw)) ? value[b] : fill;
        end
        return ext;
    endfunction

    // Clamp a signed value into [-2^(aw-1), 2^(aw-1)-1].
    function automatic logic [63:0] clamp_sat(
        input logic signed [63:0] acc,
        input int unsigned        aw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/seq_dot_mac_lane_tree.sv
// Combinational K-lane digit product and signed sum.
// Ports:
//   a_dig_i  [K][P+1]  signed A digits, one per lane
//   b_dig_i  [K][P+1]  signed B digits, one per lane
//   sum_o    SW        signed sum of the K lane products, SW = 2P+2+clog2(K)
module seq_dot_lane_tree #(
    parameter int K = 4,
    parameter int P = 2,
    localparam int SW = 2*P + 2 + $clog2(K)
) (
    input  logic [K-1:0][P:0]     a_dig_i,
    input  logic [K-1:0][P:0]     b_dig_i,
    output logic signed [SW-1:0]  sum_o
);

    logic signed [2*P+1:0] w_prod;
    logic signed [SW-1:0]  w_sum;

    // Multiply each lane's digit pair and add the lane products together
    always_comb begin
        w_sum  = {SW{1'b0}};
        w_prod = {(2*P+2){1'b0}};
        for (int k = 0; k < K; k++) begin
            w_prod = (2*P+2)'($signed(a_dig_i[k])) * (2*P+2)'($signed(b_dig_i[k]));
            w_sum  = w_sum + SW'(w_prod);
        end
    end

    assign sum_o = w_sum;

endmodule

// File: rtl/seq_dot_mac.sv
// Digit-serial K-lane dot-product MAC: d = c + sum_k row[k]*col[k].
// One P-bit digit pair per lane per cycle, A digit inner loop, B digit outer.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i / ready_o        request handshake (operands latched on accept)
//   row_i, col_i, c_i        lane operands and accumulator seed
//   size_a_i, size_b_i       precisions in digits (0 or >ND means ND)
//   signed_a_i, signed_b_i   operand signedness
//   valid_o / ready_i        result handshake
//   d_o                      result, held after the handshake
// Macro SEQ_DOT_MAC_SATURATE_EN: saturate d_o instead of wrapping.
module seq_dot_mac
    import seq_dot_mac_pkg::*;
#(
    parameter int K         = 4,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int ACC_WIDTH = 32,
    localparam int ND  = MAX_WIDTH / P,
    localparam int SZW = $clog2(ND) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [K-1:0][MAX_WIDTH-1:0]   row_i,
    input  logic [K-1:0][MAX_WIDTH-1:0]   col_i,
    input  logic [ACC_WIDTH-1:0]          c_i,
    input  logic [SZW-1:0]                size_a_i,
    input  logic [SZW-1:0]                size_b_i,
    input  logic                          signed_a_i,
    input  logic                          signed_b_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [ACC_WIDTH-1:0]          d_o
);

    localparam int LOGK  = $clog2(K);
    localparam int SW    = 2*P + 2 + LOGK;
    localparam int IW_B  = 2*MAX_WIDTH + LOGK;
    localparam int INT_W = ((ACC_WIDTH > IW_B) ? ACC_WIDTH : IW_B) + 1;
    localparam logic [SZW-1:0] ND_SZ  = SZW'(ND);
    localparam logic [SZW-1:0] ONE_SZ = SZW'(1'b1);
    localparam logic [SZW-1:0] ZERO_SZ = {SZW{1'b0}};

    state_e                        r_state;
    state_e                        w_state_nx;
    logic [K-1:0][MAX_WIDTH-1:0]   r_row;
    logic [K-1:0][MAX_WIDTH-1:0]   r_col;
    logic [SZW-1:0]                r_na;
    logic [SZW-1:0]                r_nb;
    logic                          r_sa;
    logic                          r_sb;
    logic [SZW-1:0]                r_i;
    logic [SZW-1:0]                r_j;
    logic signed [INT_W-1:0]       r_acc;
    logic [ACC_WIDTH-1:0]          r_d;
    logic                          r_valid;

    logic                          w_accept;
    logic                          w_last;
    logic [SZW-1:0]                w_na;
    logic [SZW-1:0]                w_nb;
    logic [7:0]                    w_a_off;
    logic [7:0]                    w_b_off;
    logic [7:0]                    w_shamt;
    logic [K-1:0][P:0]             w_a_dig;
    logic [K-1:0][P:0]             w_b_dig;
    logic signed [SW-1:0]          w_sum;
    logic signed [INT_W-1:0]       w_term;
    logic signed [INT_W-1:0]       w_acc_nx;
    logic [ACC_WIDTH-1:0]          w_d_nx;

    // ready_o depends on ready_i so a finished result can hand over to a new request in one cycle
    assign ready_o  = (r_state == IDLE) | ((r_state == DONE) & ready_i);
    assign w_accept = valid_i & ready_o;
    assign valid_o  = r_valid;
    assign d_o      = r_d;

    // Clamp requested precisions: 0 or anything above ND means full width
    always_comb begin
        w_na = size_a_i;
        w_nb = size_b_i;
        if ((size_a_i == ZERO_SZ) || (size_a_i > ND_SZ)) begin
            w_na = ND_SZ;
        end else begin
            w_na = size_a_i;
        end
        if ((size_b_i == ZERO_SZ) || (size_b_i > ND_SZ)) begin
            w_nb = ND_SZ;
        end else begin
            w_nb = size_b_i;
        end
    end

    // Select and extend the current digit of every lane
    always_comb begin
        w_a_off = 8'(r_i) * 8'(P);
        w_b_off = 8'(r_j) * 8'(P);
        w_a_dig = {(K*(P+1)){1'b0}};
        w_b_dig = {(K*(P+1)){1'b0}};
        for (int k = 0; k < K; k++) begin
            w_a_dig[k] = (P+1)'(digit_ext(DIG_MAX'(r_row[k][w_a_off +: P]),
                                          8'(r_i), 8'(r_na), r_sa, P));
            w_b_dig[k] = (P+1)'(digit_ext(DIG_MAX'(r_col[k][w_b_off +: P]),
                                          8'(r_j), 8'(r_nb), r_sb, P));
        end
    end

    seq_dot_lane_tree #(
        .K (K),
        .P (P)
    ) u_lane_tree (
        .a_dig_i (w_a_dig),
        .b_dig_i (w_b_dig),
        .sum_o   (w_sum)
    );

    // Weight the lane sum by the digit positions and form the next accumulator
    always_comb begin
        w_shamt  = 8'(P) * (8'(r_i) + 8'(r_j));
        w_term   = INT_W'(w_sum) <<< w_shamt;
        w_acc_nx = r_acc + w_term;
        w_last   = (r_i == (r_na - ONE_SZ)) & (r_j == (r_nb - ONE_SZ));
`ifdef SEQ_DOT_MAC_SATURATE_EN
        w_d_nx   = ACC_WIDTH'(clamp_sat(64'(w_acc_nx), ACC_WIDTH));
`else
        w_d_nx   = w_acc_nx[ACC_WIDTH-1:0];
`endif
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = RUN;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = RUN;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_state_nx = RUN;
                end else if (ready_i) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = DONE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, digit counters and shift-accumulate
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row <= {(K*MAX_WIDTH){1'b0}};
            r_col <= {(K*MAX_WIDTH){1'b0}};
            r_na  <= ZERO_SZ;
            r_nb  <= ZERO_SZ;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_i   <= ZERO_SZ;
            r_j   <= ZERO_SZ;
            r_acc <= {INT_W{1'b0}};
        end else if (w_accept) begin
            r_row <= row_i;
            r_col <= col_i;
            r_na  <= w_na;
            r_nb  <= w_nb;
            r_sa  <= signed_a_i;
            r_sb  <= signed_b_i;
            r_i   <= ZERO_SZ;
            r_j   <= ZERO_SZ;
            r_acc <= INT_W'($signed(c_i));
        end else if (r_state == RUN) begin
            r_acc <= w_acc_nx;
            // i is the inner (A) digit loop, j the outer (B) digit loop
            if (r_i == (r_na - ONE_SZ)) begin
                r_i <= ZERO_SZ;
                if (r_j == (r_nb - ONE_SZ)) begin
                    r_j <= ZERO_SZ;
                end else begin
                    r_j <= r_j + ONE_SZ;
                end
            end else begin
                r_i <= r_i + ONE_SZ;
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result register and valid flag; d_o only changes when a result completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d     <= {ACC_WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_nx == DONE);
            if ((r_state == RUN) && w_last) begin
                r_d <= w_d_nx;
            end else begin
                r_d <= r_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_dot_mac.sv
// Directed self-checking bench for seq_dot_mac (K=4, P=2, MAX_WIDTH=16, ACC_WIDTH=32).
module tb_seq_dot_mac;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                valid_i;
    logic                ready_o;
    logic [3:0][15:0]    row_i;
    logic [3:0][15:0]    col_i;
    logic [31:0]         c_i;
    logic [3:0]          size_a_i;
    logic [3:0]          size_b_i;
    logic                signed_a_i;
    logic                signed_b_i;
    logic                valid_o;
    logic                ready_i;
    logic [31:0]         d_o;

    int n_tests = 0;
    int n_fail  = 0;

    seq_dot_mac #(
        .K         (4),
        .MAX_WIDTH (16),
        .P         (2),
        .ACC_WIDTH (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .row_i      (row_i),
        .col_i      (col_i),
        .c_i        (c_i),
        .size_a_i   (size_a_i),
        .size_b_i   (size_b_i),
        .signed_a_i (signed_a_i),
        .signed_b_i (signed_b_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .d_o        (d_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted; called at posedge+1, returns at posedge+1
    task automatic start_op(input logic [3:0][15:0] ra, input logic [3:0][15:0] ca,
                            input logic [31:0] cv, input logic [3:0] sza, input logic [3:0] szb,
                            input logic sga, input logic sgb);
        int guard;
        row_i = ra; col_i = ca; c_i = cv;
        size_a_i = sza; size_b_i = szb;
        signed_a_i = sga; signed_b_i = sgb;
        valid_i = 1'b1;
        guard = 0;
        while (!ready_o && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check_val("accept_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        // inputs are don't-care after accept
        row_i = {$urandom, $urandom};
        col_i = {$urandom, $urandom};
        c_i = $urandom;
        size_a_i = 4'($urandom); size_b_i = 4'($urandom);
        signed_a_i = 1'($urandom); signed_b_i = 1'($urandom);
    endtask

    // Count cycles from the accept edge until valid_o and check result and latency
    task automatic wait_result(input string tag, input logic [31:0] exp_d, input int exp_lat);
        int lat;
        lat = 1;
        while (!valid_o && lat < 300) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_d"}, {32'd0, d_o}, {32'd0, exp_d});
    endtask

    task automatic release_result(input string tag);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check_val({tag, "_vdrop"}, {63'd0, valid_o}, 64'd0);
    endtask

    logic [3:0][15:0] ra, ca, rb, cb;
    logic [31:0]      hold_d;

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        row_i = '0; col_i = '0; c_i = 32'd0;
        size_a_i = 4'd0; size_b_i = 4'd0; signed_a_i = 1'b0; signed_b_i = 1'b0;
        #1;
        check_val("rst_ready", {63'd0, ready_o}, 64'd1);
        check_val("rst_valid", {63'd0, valid_o}, 64'd0);
        check_val("rst_d", {32'd0, d_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1; rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // 1: full 8x8-digit signed dot product with seed
        ra[0] = 16'd3; ra[1] = 16'hFFFE; ra[2] = 16'd100; ra[3] = 16'h8000;
        ca[0] = 16'd5; ca[1] = 16'd7;    ca[2] = 16'hFFFF; ca[3] = 16'h8000;
        start_op(ra, ca, 32'd10, 4'd8, 4'd8, 1'b1, 1'b1);
        check_val("t1_busy", {63'd0, ready_o}, 64'd0);
        wait_result("t1", 32'd1073741735, 65);
        release_result("t1");

        // 2: one digit each, unsigned, upper operand bits ignored
        for (int k = 0; k < 4; k++) begin ra[k] = 16'hFFFF; ca[k] = 16'hFFFF; end
        start_op(ra, ca, 32'd0, 4'd1, 4'd1, 1'b0, 1'b0);
        wait_result("t2", 32'd36, 2);
        release_result("t2");

        // 3 + 4: mixed precision, then hold the result and hand over back-to-back
        ra = '0; ca = '0;
        ra[0] = 16'hFFF8; ca[0] = 16'hABFF;
        start_op(ra, ca, 32'd0, 4'd2, 4'd4, 1'b1, 1'b0);
        wait_result("t3", 32'hFFFFF808, 9);
        hold_d = d_o;
        for (int c = 0; c < 5; c++) begin
            check_val("t4_hold_v", {63'd0, valid_o}, 64'd1);
            check_val("t4_hold_d", {32'd0, d_o}, {32'd0, 32'hFFFFF808});
            check_val("t4_hold_rdy", {63'd0, ready_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        for (int k = 0; k < 4; k++) begin rb[k] = 16'hFFFF; cb[k] = 16'hFFFF; end
        row_i = rb; col_i = cb; c_i = 32'd0;
        size_a_i = 4'd1; size_b_i = 4'd1; signed_a_i = 1'b0; signed_b_i = 1'b0;
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        check_val("t4_b2b_rdy", {63'd0, ready_o}, 64'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0; ready_i = 1'b0;
        row_i = '0; col_i = '0;
        check_val("t4_b2b_vdrop", {63'd0, valid_o}, 64'd0);
        check_val("t4_b2b_dkeep", {32'd0, d_o}, {32'd0, hold_d});
        wait_result("t4_b2b", 32'd36, 2);
        release_result("t4");

        // 5: overflow past the positive limit of the 32-bit result
        ra = '0; ca = '0;
        ra[0] = 16'h8000; ca[0] = 16'h8000;
        start_op(ra, ca, 32'h7FFFFFF0, 4'd8, 4'd8, 1'b1, 1'b1);
`ifdef SEQ_DOT_MAC_SATURATE_EN
        wait_result("t5", 32'h7FFFFFFF, 65);
`else
        wait_result("t5", 32'hBFFFFFF0, 65);
`endif
        release_result("t5");

        // 7: signed A (-1) times unsigned B (65535) on lane 1
        ra = '0; ca = '0;
        ra[1] = 16'hFFFF; ca[1] = 16'hFFFF;
        start_op(ra, ca, 32'd0, 4'd8, 4'd8, 1'b1, 1'b0);
        wait_result("t7", 32'hFFFF0001, 65);
        release_result("t7");

        // 8: sizes 0 and 9 both clamp to full width; unsigned 65535^2
        ra = '0; ca = '0;
        ra[2] = 16'hFFFF; ca[2] = 16'hFFFF;
        start_op(ra, ca, 32'd0, 4'd0, 4'd9, 1'b0, 1'b0);
`ifdef SEQ_DOT_MAC_SATURATE_EN
        wait_result("t8", 32'h7FFFFFFF, 65);
`else
        wait_result("t8", 32'hFFFE0001, 65);
`endif
        release_result("t8");

        // 6: asynchronous reset in the middle of a run
        ra[0] = 16'd3; ra[1] = 16'hFFFE; ra[2] = 16'd100; ra[3] = 16'h8000;
        ca[0] = 16'd5; ca[1] = 16'd7;    ca[2] = 16'hFFFF; ca[3] = 16'h8000;
        start_op(ra, ca, 32'd10, 4'd8, 4'd8, 1'b1, 1'b1);
        repeat (10) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_val("t6_rst_valid", {63'd0, valid_o}, 64'd0);
        check_val("t6_rst_d", {32'd0, d_o}, 64'd0);
        check_val("t6_rst_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) begin ra[k] = 16'hFFFF; ca[k] = 16'hFFFF; end
        start_op(ra, ca, 32'd0, 4'd1, 4'd1, 1'b0, 1'b0);
        wait_result("t6_after", 32'd36, 2);
        release_result("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
